// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: op-field width and op codes.
package shifter_pkg;

   localparam int OP_W = 3;

   // Codes 101-111 are deliberately left unnamed: they pass the operand through.
   typedef enum logic [OP_W-1:0] {
      SHIFT_SLL = 3'b000,
      SHIFT_SRL = 3'b001,
      SHIFT_SRA = 3'b010,
      SHIFT_ROL = 3'b011,
      SHIFT_ROR = 3'b100
   } shift_op_e;

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage: conditional shift by DIST (selected by shamt bit log2(DIST)),
// followed by a valid/ready stage register carrying data, op, shamt and tag.
module shift_stage
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIST  = 1,
   parameter int TAG_W = 4,
   parameter int SW    = $clog2(WIDTH)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_data,
   input  logic [OP_W-1:0]  up_op,
   input  logic [SW-1:0]    up_shamt,
   input  logic [TAG_W-1:0] up_tag,
   output logic             dn_valid,
   input  logic             dn_ready,
   output logic [WIDTH-1:0] dn_data,
   output logic [OP_W-1:0]  dn_op,
   output logic [SW-1:0]    dn_shamt,
   output logic [TAG_W-1:0] dn_tag
);

   localparam int BIT = $clog2(DIST);

   logic [WIDTH-1:0] shifted;
   logic             load;

   always_comb begin
      shifted = up_data;
      if (up_shamt[BIT]) begin
         case (up_op)
            SHIFT_SLL: shifted = up_data << DIST;
            SHIFT_SRL: shifted = up_data >> DIST;
            SHIFT_SRA: shifted = $signed(up_data) >>> DIST;
            SHIFT_ROL: shifted = (up_data << DIST) | (up_data >> (WIDTH - DIST));
            SHIFT_ROR: shifted = (up_data >> DIST) | (up_data << (WIDTH - DIST));
            default:   shifted = up_data;
         endcase
      end
   end

   // Empty, or the occupant leaves this cycle: either way the register may be overwritten.
   assign load = !dn_valid || dn_ready;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         dn_valid <= 1'b0;
         dn_data  <= '0;
         dn_op    <= '0;
         dn_shamt <= '0;
         dn_tag   <= '0;
      end else if (load) begin
         dn_valid <= up_valid;
         if (up_valid) begin
            dn_data  <= shifted;
            dn_op    <= up_op;
            dn_shamt <= up_shamt;
            dn_tag   <= up_tag;
         end
      end
   end

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter: log2(WIDTH) registered stages, stage k shifts by 2^k,
// with valid/ready flow control and a sideband tag carried alongside each operation.
module pipe_shifter
   import shifter_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int TAG_W = 4,
   localparam int SW    = $clog2(WIDTH)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SW-1:0]    in_shamt,
   input  logic [OP_W-1:0]  in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TAG_W-1:0] out_tag
);

   // Index 0 is the upstream interface, index k+1 is the output of stage k.
   logic [SW:0]             vld;
   logic [SW:0][WIDTH-1:0]  dat;
   logic [SW:0][OP_W-1:0]   op;
   logic [SW:0][SW-1:0]     sht;
   logic [SW:0][TAG_W-1:0]  tag;
   logic [SW-1:0]           dn_rdy;
   logic                    unused_tail;

   assign vld[0] = in_valid;
   assign dat[0] = in_data;
   assign op[0]  = in_op;
   assign sht[0] = in_shamt;
   assign tag[0] = in_tag;

   // dn_rdy[k] is the readiness of stage k+1, unrolled from out_ready backwards.
   always_comb begin
      dn_rdy = '0;
      dn_rdy[SW-1] = out_ready;
      for (int k = SW - 2; k >= 0; k--) begin
         dn_rdy[k] = dn_rdy[k+1] || !vld[k+2];
      end
   end

   assign in_ready = !vld[1] || dn_rdy[0];

   for (genvar k = 0; k < SW; k++) begin : g_stage
      shift_stage #(
         .WIDTH (WIDTH),
         .DIST  (1 << k),
         .TAG_W (TAG_W),
         .SW    (SW)
      ) u_stage (
         .clock    (clock),
         .reset_n  (reset_n),
         .up_valid (vld[k]),
         .up_data  (dat[k]),
         .up_op    (op[k]),
         .up_shamt (sht[k]),
         .up_tag   (tag[k]),
         .dn_valid (vld[k+1]),
         .dn_ready (dn_rdy[k]),
         .dn_data  (dat[k+1]),
         .dn_op    (op[k+1]),
         .dn_shamt (sht[k+1]),
         .dn_tag   (tag[k+1])
      );
   end

   assign out_valid = vld[SW];
   assign out_data  = dat[SW];
   assign out_tag   = tag[SW];

   // The last stage's op and shamt are registered for uniformity but never leave the block.
   assign unused_tail = ^{op[SW], sht[SW]};

endmodule

// File: tb/tb_pipe_shifter.sv
// Bench for pipe_shifter (WIDTH=32): directed scenarios plus a randomized stream,
// scored against a whole-shift reference model.
module tb_pipe_shifter;
   import shifter_pkg::*;

   localparam int WIDTH = 32;
   localparam int TAG_W = 4;
   localparam int SW    = 5;

   typedef logic [TAG_W+WIDTH-1:0] item_t;

   logic             clock;
   logic             reset_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [SW-1:0]    in_shamt;
   logic [2:0]       in_op;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [TAG_W-1:0] out_tag;

   item_t exp_q[$];
   item_t obs_q[$];
   int    acc_cyc_q[$];
   int    obs_cyc_q[$];
   int    cyc = 0;
   int    n_checks = 0;
   int    n_pass = 0;

   pipe_shifter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_op     (in_op),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Whole-amount shift computed in one go on a double-width word.
   function automatic logic [31:0] ref_shift(input logic [2:0] op, input logic [31:0] x, input int s);
      logic [63:0] w;
      case (op)
         3'b000: return x << s;
         3'b001: return x >> s;
         3'b010: begin w = {{32{x[31]}}, x} >> s; return w[31:0]; end
         3'b011: begin w = {x, x} << s; return w[63:32]; end
         3'b100: begin w = {x, x} >> s; return w[31:0]; end
         default: return x;
      endcase
   endfunction

   always @(posedge clock) cyc++;

   // Inputs change 1 time unit after the rising edge, so the falling edge sees what the next rising edge transfers.
   always @(negedge clock) begin
      if (reset_n) begin
         if (in_valid && in_ready) begin
            exp_q.push_back({in_tag, ref_shift(in_op, in_data, int'(in_shamt))});
            acc_cyc_q.push_back(cyc);
         end
         if (out_valid && out_ready) begin
            obs_q.push_back({out_tag, out_data});
            obs_cyc_q.push_back(cyc);
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_q();
      exp_q.delete();
      obs_q.delete();
      acc_cyc_q.delete();
      obs_cyc_q.delete();
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (12) step();
   endtask

   task automatic wait_obs(input int n, input int budget, output bit ok);
      for (int i = 0; i < budget && obs_q.size() < n; i++) step();
      ok = (obs_q.size() >= n);
   endtask

   task automatic test_reset();
      in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; in_tag = '0;
      out_ready = 1'b0;
      reset_n = 1'b0;
      step(); step();
      n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
      n_checks++; if (out_data !== 32'h0) $display("FAIL reset_out_data: got %h expected 00000000", out_data); else n_pass++;
      n_checks++; if (out_tag !== 4'h0) $display("FAIL reset_out_tag: got %h expected 0", out_tag); else n_pass++;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_sra_latency();
      bit ok;
      clear_q();
      out_ready = 1'b1;
      in_valid = 1'b1; in_op = 3'b010; in_data = 32'h80000010; in_shamt = 5'd4; in_tag = 4'hA;
      step();
      in_valid = 1'b0;
      wait_obs(1, 20, ok);
      n_checks++; if (!ok) $display("FAIL sra_timeout: got %0d results expected 1", obs_q.size()); else n_pass++;
      if (ok) begin
         n_checks++; if (obs_q[0] !== {4'hA, 32'hF8000001})
            $display("FAIL sra_result: got %h expected %h", obs_q[0], {4'hA, 32'hF8000001}); else n_pass++;
         n_checks++; if (obs_cyc_q[0] - acc_cyc_q[0] != 5)
            $display("FAIL sra_latency: got %0d expected 5", obs_cyc_q[0] - acc_cyc_q[0]); else n_pass++;
      end
   endtask

   task automatic test_back_to_back_rotate();
      bit ok;
      drain(); clear_q();
      in_valid = 1'b1; in_op = 3'b011; in_data = 32'h80000001; in_shamt = 5'd1; in_tag = 4'h1;
      step();
      in_op = 3'b100; in_data = 32'h00000003; in_shamt = 5'd1; in_tag = 4'h2;
      step();
      in_valid = 1'b0;
      wait_obs(2, 20, ok);
      n_checks++; if (!ok) $display("FAIL rot_timeout: got %0d results expected 2", obs_q.size()); else n_pass++;
      if (ok) begin
         n_checks++; if (obs_q[0] !== {4'h1, 32'h00000003})
            $display("FAIL rol_result: got %h expected %h", obs_q[0], {4'h1, 32'h00000003}); else n_pass++;
         n_checks++; if (obs_q[1] !== {4'h2, 32'h80000001})
            $display("FAIL ror_result: got %h expected %h", obs_q[1], {4'h2, 32'h80000001}); else n_pass++;
         n_checks++; if (obs_cyc_q[1] - obs_cyc_q[0] != 1)
            $display("FAIL rot_consecutive: got gap %0d expected 1", obs_cyc_q[1] - obs_cyc_q[0]); else n_pass++;
      end
   endtask

   task automatic test_sll_stream_stall();
      int               rdy_pat[4] = '{1, 0, 0, 1};
      bit               prev_stall = 1'b0;
      logic [WIDTH-1:0] prev_data = '0;
      logic [TAG_W-1:0] prev_tag = '0;
      logic [31:0]      e;
      drain(); clear_q();
      for (int i = 0; i < 200 && obs_q.size() < 8; i++) begin
         step();
         if (prev_stall) begin
            n_checks++; if (out_valid !== 1'b1 || out_data !== prev_data || out_tag !== prev_tag)
               $display("FAIL stall_hold: got v=%b %h/%h expected v=1 %h/%h", out_valid, out_tag, out_data, prev_tag, prev_data);
            else n_pass++;
         end
         out_ready = (rdy_pat[i % 4] != 0);
         if (exp_q.size() < 8) begin
            in_valid = 1'b1; in_op = 3'b000; in_data = 32'h1;
            in_shamt = 5'(exp_q.size()); in_tag = 4'(exp_q.size());
         end else begin
            in_valid = 1'b0;
         end
         #3;
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_tag   = out_tag;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      n_checks++; if (obs_q.size() != 8) $display("FAIL sll_count: got %0d expected 8", obs_q.size()); else n_pass++;
      for (int k = 0; k < 8 && k < obs_q.size(); k++) begin
         e = 32'h1 << k;
         n_checks++; if (obs_q[k] !== {4'(k), e})
            $display("FAIL sll_order[%0d]: got %h expected %h", k, obs_q[k], {4'(k), e}); else n_pass++;
      end
   endtask

   task automatic test_backpressure_fill();
      bit ok;
      drain(); clear_q();
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_op = 3'($urandom_range(0, 7)); in_data = $urandom;
         in_shamt = 5'($urandom); in_tag = 4'($urandom);
         step();
      end
      n_checks++; if (exp_q.size() != 5) $display("FAIL fill_accepts: got %0d expected 5", exp_q.size()); else n_pass++;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready: got %b expected 0", in_ready); else n_pass++;
      out_ready = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL pulse_in_ready: got %b expected 1", in_ready); else n_pass++;
      step();
      out_ready = 1'b0;
      #1;
      n_checks++; if (obs_q.size() != 1) $display("FAIL pulse_one_out: got %0d expected 1", obs_q.size()); else n_pass++;
      n_checks++; if (exp_q.size() != 6) $display("FAIL pulse_refill: got %0d expected 6", exp_q.size()); else n_pass++;
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_obs(6, 30, ok);
      n_checks++; if (!ok) $display("FAIL fill_drain_timeout: got %0d expected 6", obs_q.size()); else n_pass++;
      for (int k = 0; k < 6 && k < obs_q.size(); k++) begin
         n_checks++; if (obs_q[k] !== exp_q[k])
            $display("FAIL fill_order[%0d]: got %h expected %h", k, obs_q[k], exp_q[k]); else n_pass++;
      end
   endtask

   task automatic test_reset_inflight();
      int seen_valid = 0;
      drain(); clear_q();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_op = 3'b001; in_data = $urandom;
         in_shamt = 5'($urandom); in_tag = 4'(i + 5);
         step();
      end
      in_valid = 1'b0;
      step();
      reset_n = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL async_reset_valid: got %b expected 0", out_valid); else n_pass++;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL async_reset_ready: got %b expected 1", in_ready); else n_pass++;
      step(); step();
      reset_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         if (out_valid) seen_valid++;
      end
      n_checks++; if (obs_q.size() != 0) $display("FAIL stale_results: got %0d expected 0", obs_q.size()); else n_pass++;
      n_checks++; if (seen_valid != 0) $display("FAIL stale_valid: got %0d cycles expected 0", seen_valid); else n_pass++;
      clear_q();
   endtask

   task automatic test_passthrough();
      bit          ok;
      logic [31:0] r;
      drain(); clear_q();
      r = $urandom;
      in_valid = 1'b1; in_op = 3'b101; in_data = 32'hDEADBEEF; in_shamt = 5'd7; in_tag = 4'h3;
      step();
      in_op = 3'b001; in_data = r; in_shamt = 5'd0; in_tag = 4'h4;
      step();
      in_valid = 1'b0;
      wait_obs(2, 20, ok);
      n_checks++; if (!ok) $display("FAIL pass_timeout: got %0d expected 2", obs_q.size()); else n_pass++;
      if (ok) begin
         n_checks++; if (obs_q[0] !== {4'h3, 32'hDEADBEEF})
            $display("FAIL op101_pass: got %h expected %h", obs_q[0], {4'h3, 32'hDEADBEEF}); else n_pass++;
         n_checks++; if (obs_q[1] !== {4'h4, r})
            $display("FAIL srl0_pass: got %h expected %h", obs_q[1], {4'h4, r}); else n_pass++;
      end
   endtask

   task automatic test_random_stream();
      bit ok;
      int n_exp;
      drain(); clear_q();
      for (int i = 0; i < 300; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_op     = 3'($urandom_range(0, 7));
         in_data   = $urandom;
         in_shamt  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         in_tag    = 4'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      n_exp = exp_q.size();
      wait_obs(n_exp, 40, ok);
      n_checks++; if (!ok || obs_q.size() != n_exp)
         $display("FAIL random_count: got %0d expected %0d", obs_q.size(), n_exp); else n_pass++;
      for (int k = 0; k < n_exp && k < obs_q.size(); k++) begin
         n_checks++; if (obs_q[k] !== exp_q[k])
            $display("FAIL random_item[%0d]: got %h expected %h", k, obs_q[k], exp_q[k]); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_sra_latency();
      test_back_to_back_rotate();
      test_sll_stream_stall();
      test_backpressure_fill();
      test_reset_inflight();
      test_passthrough();
      test_random_stream();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipe_shifter.md
PIPE_SHIFTER -- requirements
Module: pipe_shifter

Interface
REQ-001 Parameter WIDTH, default 32, data width; SHALL be a power of two, 8 to 64.
REQ-002 Parameter TAG_W, default 4, width of the sideband tag carried alongside each operation.
REQ-003 Derived constant SW = log2(WIDTH) SHALL set the shift-amount width and the number of pipeline stages.
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream holds a valid operation.
REQ-007 in_ready  output  1  block accepts an operation this cycle.
REQ-008 in_data  input  WIDTH  operand to shift.
REQ-009 in_shamt  input  SW  shift amount, unsigned.
REQ-010 in_op  input  3  operation code.
REQ-011 in_tag  input  TAG_W  sideband tag, carried through unchanged.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 out_data  output  WIDTH  shifted result.
REQ-015 out_tag  output  TAG_W  tag of the operation that produced out_data.

Function
REQ-016 Op encodings SHALL be: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; the codes 101-111 SHALL pass the operand through unchanged.
REQ-017 SLL and SRL SHALL fill vacated bits with zero; SRA SHALL fill with operand bit WIDTH-1; ROL and ROR SHALL rotate modulo WIDTH.
REQ-018 The pipeline SHALL have SW registered stages; stage k SHALL apply a shift of 2^k when shamt bit k is 1, and otherwise pass its data through.
REQ-019 Each stage SHALL register valid, data, op, shamt and tag together.
REQ-020 A transfer SHALL occur at the input when in_valid and in_ready are both 1, and at the output when out_valid and out_ready are both 1.
REQ-021 Stage k SHALL be ready when its valid bit is 0 or when stage k+1 is ready; the last stage's downstream-ready SHALL be out_ready.
REQ-022 in_ready SHALL equal stage 0 ready, and SHALL be combinational from out_ready through the stage valids.
REQ-023 Latency SHALL be exactly SW cycles from input transfer to out_valid while out_ready is held at 1; throughput SHALL be one operation per cycle.
REQ-024 Under backpressure (out_ready=0), a stage holding a valid result SHALL hold its contents stable, and no operation SHALL be dropped or duplicated.
REQ-025 A stage SHALL load and drain in the same cycle when it is full and ready.
REQ-026 Results SHALL leave in acceptance order.
REQ-027 shamt=0 SHALL return the operand unchanged for every op.
REQ-028 out_data and out_tag SHALL hold their value while out_valid=1 and out_ready=0.

Reset
REQ-029 Asserting reset_n=0 SHALL clear all stage valid bits, data, op, shamt and tag registers to 0 immediately, without waiting for a clock edge.
REQ-030 After reset: out_valid=0, out_data=0, out_tag=0, in_ready=1.
REQ-031 Operations in flight when reset asserts SHALL be discarded, and no output transfer SHALL occur for them.
REQ-032 Release of reset SHALL take effect on the first clock edge after reset_n rises.

Structure
REQ-033 Package shifter_pkg SHALL hold the op encodings (SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROL, SHIFT_ROR) and the op-field width constant.
REQ-034 Sub-module shift_stage, parameterised by WIDTH and DIST, SHALL implement one combinational conditional shift by DIST for all ops plus its stage register with handshake.
REQ-035 pipe_shifter SHALL instantiate SW shift_stage instances with DIST = 1, 2, 4, ... WIDTH/2 via a generate loop.

Verification (WIDTH=32, latency 5)
REQ-036 SRA of 0x80000010 by 4, out_ready=1 -> out_data=0xF8000001 exactly 5 cycles after acceptance, with the tag preserved.
REQ-037 ROL of 0x80000001 by 1, then ROR of 0x00000003 by 1, back-to-back -> outputs 0x00000003 then 0x80000001 on consecutive cycles.
REQ-038 Stream of 8 SLL ops of 0x1 by shamt 0..7 with out_ready toggling 1,0,0,1 -> outputs 0x1, 0x2, ... 0x80 in order, with none lost and out_data stable while stalled.
REQ-039 Fill the pipe with out_ready=0 -> in_ready drops after 5 accepts; one out_ready pulse -> exactly one result leaves and in_ready returns to 1 in the same cycle.
REQ-040 reset_n pulsed low with 3 ops in flight -> out_valid=0 immediately and no stale result appears after release.
REQ-041 Op 101 with 0xDEADBEEF and shamt 7, plus SRL with shamt 0 -> output unchanged in both cases.
